// File: rtl/cell_tb_pkg.sv
// Shared FSM encoding and truth-table constants for library-cell sweep sequencers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cell_tb_pkg;

   // Sweep FSM state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   // Truth tables: bit i is the cell output for input vector i (MSB of the vector = first pin)
   localparam logic [15:0] TT_OAI22 = 16'h111F;
   localparam logic [15:0] TT_AOI22 = 16'h0777;
   localparam logic [3:0]  TT_NAND2 = 4'h7;
   localparam logic [3:0]  TT_NOR2  = 4'h1;
   localparam logic [3:0]  TT_AND2  = 4'h8;
   localparam logic [3:0]  TT_OR2   = 4'hE;
   localparam logic [1:0]  TT_INV   = 2'h1;

   // Width of a counter that must hold values 0..n-1 (at least one bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cell_vec_checker.sv
// Compares one sampled cell output against its expected bit and keeps a saturating mismatch count.
// Latency: mismatch is combinational; err_count updates on the clock edge ending the sample cycle.
// Backpressure: none; every sample_en cycle is evaluated.
module cell_vec_checker #(
   parameter int N_IN = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            sample_en,
   input  logic            dut_out,
   input  logic            exp_bit,
   output logic            mismatch,
   output logic [N_IN:0]   err_count
);

   // Count saturates at the number of vectors in a sweep
   localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

   // Case inequality so an X/Z cell output counts as a mismatch in simulation
   always_comb begin
      mismatch = (dut_out !== exp_bit);
   end

   // Saturating mismatch counter, cleared at the start of each sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clear) begin
         err_count <= '0;
      end else if (sample_en && mismatch && (err_count != ERR_MAX)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: rtl/cell_vector_sequencer.sv
// Sweeps all 2^N_IN cell input vectors, holds each SETTLE_CYCLES+1 clocks, checks the output vs EXPECT.
// Latency: full sweep is 2^N_IN*(SETTLE_CYCLES+1) clocks from start accept to done rising.
// Backpressure: start is ignored while a sweep is in progress; no other flow control.
module cell_vector_sequencer
   import cell_tb_pkg::*;
#(
   parameter int                   N_IN          = 4,
   parameter int                   SETTLE_CYCLES = 2,
   parameter logic [2**N_IN-1:0]   EXPECT        = 16'h111F
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   vec_out,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              fail_valid,
   output logic [N_IN-1:0]   fail_vec
);

   localparam int                CW          = cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0]   IDX_LAST    = '1;

   seq_state_t          state;
   seq_state_t          state_nxt;
   logic [N_IN-1:0]     idx;
   logic [CW-1:0]       settle_cnt;
   logic                settle_end;
   logic                last_vec;
   logic                exp_bit;
   logic                mismatch;
   logic                start_ok;
   logic                in_settle;
   logic                do_sample;

   assign settle_end = (settle_cnt == SETTLE_LAST);
   assign last_vec   = (idx == IDX_LAST);
   assign exp_bit    = EXPECT[idx];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: terminal vector is found by compare, so idx never wraps
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start)      state_nxt = SETTLE;
         SETTLE:     if (settle_end) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = last_vec ? DONE : SETTLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Control strobes decoded from the current state
   always_comb begin
      start_ok  = 1'b0;
      in_settle = 1'b0;
      do_sample = 1'b0;
      case (state)
         IDLE, DONE: start_ok  = start;
         SETTLE:     in_settle = 1'b1;
         SAMPLE:     do_sample = 1'b1;
         default:    ;
      endcase
   end

   // Vector index, settle timer and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (start_ok) begin
         idx        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else if (in_settle) begin
         settle_cnt <= settle_cnt + 1'b1;
      end else if (do_sample) begin
         settle_cnt <= '0;
         if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Mismatch report: pulse and vector index appear together the cycle after the sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         fail_valid <= do_sample && mismatch;
         if (do_sample && mismatch) begin
            fail_vec <= idx;
         end
      end
   end

   cell_vec_checker #(
      .N_IN (N_IN)
   ) u_checker (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start_ok),
      .sample_en (do_sample),
      .dut_out   (dut_out),
      .exp_bit   (exp_bit),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   assign vec_out = idx;
   assign pass    = done && (err_count == '0);

endmodule
